// File: rtl/bla_arith_pkg.sv
// Shared types and the borrow-lookahead helper used by the subtractor cells and halves.
package bla_arith_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;
  localparam int unsigned CELL          = 4;
  localparam int unsigned LA_MAX        = 32;

  typedef logic [0:15] word_t;

  typedef struct packed {
    logic borrow;
    logic zero;
    logic overflow;
  } sub_flags_t;

  // Borrow into position n, as a flat sum of products over generate/propagate terms:
  // cin & p0..p(n-1)  |  OR over j<n of  g_j & p(j+1)..p(n-1).
  function automatic logic la_borrow(input logic [0:LA_MAX-1] g,
                                     input logic [0:LA_MAX-1] p,
                                     input logic cin,
                                     input int unsigned n);
    logic acc;
    logic term;
    acc  = cin;
    term = 1'b0;
    for (int unsigned k = 0; k < LA_MAX; k++) begin
      if (k < n) acc = acc & p[k];
    end
    for (int unsigned j = 0; j < LA_MAX; j++) begin
      if (j < n) begin
        term = g[j];
        for (int unsigned k = j + 1; k < LA_MAX; k++) begin
          if (k < n) term = term & p[k];
        end
        acc = acc | term;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/bla_sub4_cell.sv
// Borrow-lookahead subtractor cell: difference bits plus group borrow G / propagate P.
module bla_sub4_cell
  import bla_arith_pkg::*;
#(
  parameter int unsigned N = CELL
) (
  input  logic [0:N-1] a,
  input  logic [0:N-1] b,
  input  logic         bin,
  output logic [0:N-1] d,
  output logic         G,
  output logic         P
);

  logic [0:LA_MAX-1] gx;
  logic [0:LA_MAX-1] px;

  always_comb begin
    gx = '0;
    px = '0;
    for (int unsigned i = 0; i < N; i++) begin
      gx[i] = ~a[i] & b[i];
      px[i] = ~(a[i] ^ b[i]);
    end
  end

  always_comb begin
    d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      d[i] = a[i] ^ b[i] ^ la_borrow(gx, px, bin, i);
    end
  end

  assign G = la_borrow(gx, px, 1'b0, N);
  assign P = &px[0:N-1];

endmodule

// File: rtl/bla_sub16_pipe.sv
// Two-stage valid/ready pipelined subtractor: low half in S1, high half and flags in S2.
module bla_sub16_pipe #(
  parameter int unsigned WIDTH = bla_arith_pkg::WIDTH_DEFAULT,
  parameter int unsigned CELL  = bla_arith_pkg::CELL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             overflow
);
  import bla_arith_pkg::*;

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned NC = H / CELL;

  logic             s1_valid_q;
  logic             out_valid_q;
  logic [0:H-1]     lo_diff_q;
  logic [0:H-1]     a_hi_q;
  logic [0:H-1]     b_hi_q;
  logic             lo_borrow_q;
  logic [0:WIDTH-1] diff_q;
  logic [0:WIDTH-1] diff_d;
  sub_flags_t       flags_q;
  sub_flags_t       flags_d;

  logic [0:WIDTH-1]  cell_a;
  logic [0:WIDTH-1]  cell_b;
  logic [0:WIDTH-1]  cell_d;
  logic [0:2*NC-1]   cell_g;
  logic [0:2*NC-1]   cell_p;
  logic [0:2*NC-1]   cell_bin;
  logic [0:LA_MAX-1] lo_gx, lo_px, hi_gx, hi_px;
  logic              lo_bout;
  logic              hi_bout;
  logic              s1_free, s2_free, s1_load, s2_load;

  // Low-half cells see the live operands; high-half cells see the S1 copy.
  always_comb begin
    cell_a            = '0;
    cell_b            = '0;
    cell_a[0:H-1]     = a[0:H-1];
    cell_b[0:H-1]     = b[0:H-1];
    cell_a[H:WIDTH-1] = a_hi_q;
    cell_b[H:WIDTH-1] = b_hi_q;
  end

  for (genvar c = 0; c < 2 * NC; c++) begin : g_cell
    bla_sub4_cell #(.N(CELL)) u_cell (
      .a   (cell_a[c*CELL +: CELL]),
      .b   (cell_b[c*CELL +: CELL]),
      .bin (cell_bin[c]),
      .d   (cell_d[c*CELL +: CELL]),
      .G   (cell_g[c]),
      .P   (cell_p[c])
    );
  end

  always_comb begin
    lo_gx    = '0;
    lo_px    = '0;
    hi_gx    = '0;
    hi_px    = '0;
    cell_bin = '0;
    for (int unsigned k = 0; k < NC; k++) begin
      lo_gx[k] = cell_g[k];
      lo_px[k] = cell_p[k];
      hi_gx[k] = cell_g[NC + k];
      hi_px[k] = cell_p[NC + k];
    end
    for (int unsigned k = 0; k < NC; k++) begin
      cell_bin[k]      = la_borrow(lo_gx, lo_px, borrow_in, k);
      cell_bin[NC + k] = la_borrow(hi_gx, hi_px, lo_borrow_q, k);
    end
    lo_bout = la_borrow(lo_gx, lo_px, borrow_in, NC);
    hi_bout = la_borrow(hi_gx, hi_px, lo_borrow_q, NC);
  end

  always_comb begin
    diff_d              = '0;
    diff_d[0:H-1]       = lo_diff_q;
    diff_d[H:WIDTH-1]   = cell_d[H:WIDTH-1];
    flags_d.borrow      = hi_bout;
    flags_d.zero        = (diff_d == '0);
    flags_d.overflow    = (a_hi_q[H-1] != b_hi_q[H-1]) && (diff_d[WIDTH-1] != a_hi_q[H-1]);
  end

  assign s2_free  = ~out_valid_q | out_ready;
  assign s1_free  = ~s1_valid_q | s2_free;
  assign s1_load  = in_valid & s1_free & ~rst;
  assign s2_load  = s1_valid_q & s2_free;
  assign in_ready = s1_free & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      lo_diff_q   <= '0;
      lo_borrow_q <= 1'b0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      flags_q     <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q  <= 1'b1;
        lo_diff_q   <= cell_d[0:H-1];
        lo_borrow_q <= lo_bout;
        a_hi_q      <= a[H:WIDTH-1];
        b_hi_q      <= b[H:WIDTH-1];
      end else if (s2_load) begin
        s1_valid_q  <= 1'b0;
      end
      if (s2_load) begin
        out_valid_q <= 1'b1;
        diff_q      <= diff_d;
        flags_q     <= flags_d;
      end else if (s2_free) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign diff       = diff_q;
  assign borrow_out = flags_q.borrow;
  assign zero       = flags_q.zero;
  assign overflow   = flags_q.overflow;

endmodule
